// File: rtl/iter_div_datapath.sv
// Restoring-division datapath slaved to the start/do_iter/ready controller; one quotient bit per do_iter.
// Optional macro ITER_DIV_DIV0_DETECT_EN adds the divide-by-zero flag register behind div0.
module iter_div_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             do_iter,
   input  logic             ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             valid,
   output logic             div0
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem, quo, dvs;
   logic [CW-1:0]    cnt;
   logic             busy;
   logic [WIDTH:0]   t, d;
   logic             load, iter, fin;

   assign load = start && !busy;
   assign iter = do_iter && (cnt != '0);
   assign fin  = ready && busy;
   assign zero = (cnt == '0);

   // d[WIDTH] is the borrow: set means the divisor did not fit this step
   always_comb begin
      t = {rem, quo[WIDTH-1]};
      d = t - {1'b0, dvs};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem  <= '0;
         quo  <= '0;
         dvs  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (load) begin
         quo  <= dividend;
         rem  <= '0;
         dvs  <= divisor;
         cnt  <= CW'(WIDTH);
         busy <= 1'b1;
      end else begin
         if (iter) begin
            if (!d[WIDTH]) begin
               rem <= d[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
               rem <= t[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
         end
         if (fin) busy <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         valid     <= 1'b0;
      end else begin
         valid <= fin;
         if (fin) begin
            quotient  <= quo;
            remainder <= rem;
         end
      end
   end

`ifdef ITER_DIV_DIV0_DETECT_EN
   logic dz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dz   <= 1'b0;
         div0 <= 1'b0;
      end else begin
         if (load) dz <= (divisor == '0);
         if (fin) div0 <= dz;
      end
   end
`else
   assign div0 = 1'b0;
`endif

endmodule

// File: doc/iter_div_datapath.md
# iter_div_datapath

Iterative restoring-division datapath driven by the two-bit start/zero/do_iter/ready controller FSM. It sits directly downstream of that controller: it consumes `do_iter` and `ready` and feeds back `zero`, performing one quotient bit per iteration. It publishes a registered quotient/remainder pair with a one-cycle `valid` strobe to the next stage.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width in bits; legal range 2..32.

Ports:
- `clk`  in  1  clock; all registers update on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high; one clock domain.
- `start`  in  1  start request; the same signal the controller samples.
- `do_iter`  in  1  iteration command from the controller.
- `ready`  in  1  operation-finished indication from the controller.
- `dividend`  in  WIDTH  dividend; sampled on the load edge only.
- `divisor`  in  WIDTH  divisor; sampled on the load edge only.
- `zero`  out  1  iteration counter is exhausted, i.e. `cnt == 0`; combinational from the registered count.
- `quotient`  out  WIDTH  registered result quotient.
- `remainder`  out  WIDTH  registered result remainder.
- `valid`  out  1  one-cycle strobe; `quotient`/`remainder` are updated in this cycle.
- `div0`  out  1  divide-by-zero flag, qualified by `valid` (see Configuration).

## Operation
Internal registers:
- `rem` (WIDTH bits), `quo` (WIDTH bits), `dvs` (WIDTH bits).
- `cnt`, $clog2(WIDTH+1) bits.
- `busy` (1 bit) and `dz` (1 bit).

Reset:
- All internal registers go to 0, so `zero` = 1 after reset.
- `quotient` = 0, `remainder` = 0, `valid` = 0, `div0` = 0.

Load:
- Condition: `start` = 1 and `busy` = 0.
- Action: `quo` <= `dividend`, `rem` <= 0, `dvs` <= `divisor`, `cnt` <= WIDTH, `busy` <= 1, `dz` <= (`divisor` == 0).
- `start` while `busy` = 1 is ignored.

Iterate:
- Condition: `do_iter` = 1 and `cnt` != 0.
- Form `t` = {`rem`, `quo[WIDTH-1]`}, WIDTH+1 bits, then `d` = `t` - {1'b0, `dvs`}.
- If `d` has no borrow (bit WIDTH clear): `rem` <= `d[WIDTH-1:0]` and `quo` <= {`quo[WIDTH-2:0]`, 1}.
- Otherwise: `rem` <= `t[WIDTH-1:0]` and `quo` <= {`quo[WIDTH-2:0]`, 0}.
- `cnt` <= `cnt` - 1.
- `do_iter` with `cnt` = 0 is a no-op. This is mandatory: the controller issues one trailing `do_iter` in the cycle where `zero` rises.

Finish:
- Condition: `ready` = 1.
- Action: `quotient` <= `quo`, `remainder` <= `rem`, `div0` <= `dz`, `valid` <= 1 for exactly one cycle, `busy` <= 0.
- `ready` while `busy` = 0 is ignored; `valid` stays 0.

Arithmetic:
- Exactly WIDTH iterations are performed per operation.
- Result satisfies `dividend` = `quotient`*`divisor` + `remainder`, with `remainder` < `divisor`, for `divisor` != 0.
- Divisor 0 naturally yields `quotient` = all ones and `remainder` = `dividend`.

## Timing
Relative to `start` high in cycle 0 with the controller idle:
- Edge 1: load.
- Cycle 1: controller in its initial state; `zero` = 0.
- Cycles 2..WIDTH+1: iterations, with `cnt` counting WIDTH..1.
- Cycle WIDTH+2: `zero` = 1; the trailing `do_iter` is ignored.
- Cycle WIDTH+3: `ready` = 1.
- Cycle WIDTH+4: `valid` = 1.

Boundary behaviour:
- Latency: `valid` rises WIDTH+4 cycles after the `start` cycle.
- Results hold until the next finish.
- `start` in the `ready` cycle: ignored by both the controller and the datapath, since `busy` is still 1.
- `start` in the `valid` cycle: accepted.
- `rst` mid-operation: immediate return to reset values; no `valid` is produced for the aborted operation.

## Configuration
- `ITER_DIV_DIV0_DETECT_EN` defined: `dz` register implemented; `div0` = `dz` latched at finish and held with the results.
- Not defined: `dz` is removed; the `div0` port stays present and is tied to 0.
- The quotient/remainder behaviour is identical in both builds.

## Test plan
All scenarios run with the real controller and WIDTH = 8.
- Reset then idle: after `rst` release, `zero` = 1, `valid` = 0, `quotient` = 0, `remainder` = 0.
- 100 / 7: `valid` in cycle 12 with `quotient` = 14, `remainder` = 2, `div0` = 0.
- 255 / 1 then 5 / 9, back-to-back with `start` held high through the `valid` cycle: first result 255 r 0, second result 0 r 5. The second `valid` arrives 12 cycles after the first `valid`.
- 37 / 0 with the macro defined: `quotient` = 255, `remainder` = 37, `div0` = 1. Without the macro: the same values with `div0` = 0.
- `start` pulsed during iteration and during `ready`: no reload, and the result is unchanged (200 / 13 gives 15 r 5).
- `rst` asserted in cycle 5 of 200 / 13: outputs return to 0, no `valid`. A new 9 / 3 afterwards gives 3 r 0.
